// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, T-state encodings and ALU selects for the 8-bit bus CPU (CU_JMP_EN adds OP_JMP decode)
package cpu_pkg;
  localparam int DATA_W = 8;
  localparam int OP_W   = 4;

  typedef enum logic [2:0] {
    T1 = 3'd0,
    T2 = 3'd1,
    T3 = 3'd2,
    T4 = 3'd3,
    T5 = 3'd4
  } tstate_e;

  localparam logic [OP_W-1:0] OP_LDA = 4'h0;
  localparam logic [OP_W-1:0] OP_ADD = 4'h1;
  localparam logic [OP_W-1:0] OP_SUB = 4'h2;
  localparam logic [OP_W-1:0] OP_STA = 4'h3;
  localparam logic [OP_W-1:0] OP_LDI = 4'h4;
  localparam logic [OP_W-1:0] OP_JMP = 4'h5;
  localparam logic [OP_W-1:0] OP_OUT = 4'hE;
  localparam logic [OP_W-1:0] OP_HLT = 4'hF;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;

  // Opcodes whose T3 places the zero-extended operand nibble on the bus.
  function automatic logic uses_operand(input logic [OP_W-1:0] op);
    logic hit;
    hit = (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) ||
          (op == OP_STA) || (op == OP_LDI);
`ifdef CU_JMP_EN
    hit = hit || (op == OP_JMP);
`endif
    return hit;
  endfunction
endpackage

// File: rtl/control_unit_if.sv
// rtl/control_unit_if.sv - control enables, debug taps and prog_en between control_unit and datapath (CU_JMP_EN adds pc_ld)
interface control_unit_if;
  import cpu_pkg::*;

  logic            prog_en;
  logic            pc_out_en;
  logic            pc_cnt_en;
  logic            mar_en;
  logic            ram_rd;
  logic            ram_wr;
  logic            reg_A_wr;
  logic            reg_A_rd;
  logic            reg_B_wr;
  logic            reg_B_rd;
  logic            alu_en;
  logic [1:0]      alu_sel;
  logic            seg7_en;
  logic            halt;
  logic [2:0]      tstate;
  logic [OP_W-1:0] opcode;
`ifdef CU_JMP_EN
  logic            pc_ld;
`endif

  modport master (
    input  prog_en,
    output pc_out_en, pc_cnt_en, mar_en, ram_rd, ram_wr,
    output reg_A_wr, reg_A_rd, reg_B_wr, reg_B_rd,
    output alu_en, alu_sel, seg7_en, halt, tstate, opcode
`ifdef CU_JMP_EN
    , output pc_ld
`endif
  );

  modport slave (
    output prog_en,
    input  pc_out_en, pc_cnt_en, mar_en, ram_rd, ram_wr,
    input  reg_A_wr, reg_A_rd, reg_B_wr, reg_B_rd,
    input  alu_en, alu_sel, seg7_en, halt, tstate, opcode
`ifdef CU_JMP_EN
    , input pc_ld
`endif
  );
endinterface

// File: rtl/instr_reg_8bit.sv
// rtl/instr_reg_8bit.sv - instruction register with load enable and tri-state zero-extended operand driver
module instr_reg_8bit
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              clr_n,
  input  logic              ld,
  input  logic              oe,
  inout  wire  [DATA_W-1:0] bus,
  output logic [DATA_W-1:0] ir
);

  // Capture the fetched instruction byte from the bus.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      ir <= '0;
    end else if (ld) begin
      ir <= bus;
    end
  end

  assign bus = oe ? {{(DATA_W-OP_W){1'b0}}, ir[OP_W-1:0]} : {DATA_W{1'bz}};

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - T-state sequencer and control decode for the 8-bit bus CPU (optional JMP via CU_JMP_EN)
module control_unit
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              clr_n,
  inout  wire  [DATA_W-1:0] bus,
  control_unit_if.master    cu
);

  tstate_e           state_q;
  tstate_e           state_d;
  logic              halt_q;
  logic              halt_hit;
  logic              run;
  logic              ir_ld;
  logic              ir_oe;
  logic [DATA_W-1:0] ir;
  logic [OP_W-1:0]   op;

  assign op       = ir[DATA_W-1:DATA_W-OP_W];
  assign halt_hit = (state_q == T3) && (op == OP_HLT);
  // Reset and programming mode both silence every enable immediately.
  assign run      = clr_n && !cu.prog_en && !halt_q;

  instr_reg_8bit u_ir (
    .clk   (clk),
    .clr_n (clr_n),
    .ld    (ir_ld),
    .oe    (ir_oe),
    .bus   (bus),
    .ir    (ir)
  );

  // State register: halt wins over prog_en, prog_en parks the sequencer at T1.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= T1;
      halt_q  <= 1'b0;
    end else if (halt_hit) begin
      halt_q  <= 1'b1;
    end else if (cu.prog_en) begin
      state_q <= T1;
    end else begin
      state_q <= state_d;
    end
  end

  // Next T-state from current state and opcode.
  always_comb begin
    state_d = T1;
    case (state_q)
      T1: state_d = T2;
      T2: state_d = T3;
      T3: begin
        if (op == OP_HLT) begin
          state_d = T3;
        end else if (op == OP_LDA || op == OP_ADD || op == OP_SUB || op == OP_STA) begin
          state_d = T4;
        end else begin
          state_d = T1;
        end
      end
      T4: state_d = (op == OP_ADD || op == OP_SUB) ? T5 : T1;
      default: state_d = T1;
    endcase
  end

  // Control enables decoded from T-state and opcode.
  always_comb begin
    cu.pc_out_en = 1'b0;
    cu.pc_cnt_en = 1'b0;
    cu.mar_en    = 1'b0;
    cu.ram_rd    = 1'b0;
    cu.ram_wr    = 1'b0;
    cu.reg_A_wr  = 1'b0;
    cu.reg_A_rd  = 1'b0;
    cu.reg_B_wr  = 1'b0;
    cu.reg_B_rd  = 1'b0;
    cu.alu_en    = 1'b0;
    cu.alu_sel   = ALU_ADD;
    cu.seg7_en   = 1'b0;
`ifdef CU_JMP_EN
    cu.pc_ld     = 1'b0;
`endif
    ir_ld        = 1'b0;
    ir_oe        = 1'b0;
    if (run) begin
      case (state_q)
        T1: begin
          cu.pc_out_en = 1'b1;
          cu.mar_en    = 1'b1;
        end
        T2: begin
          cu.ram_rd    = 1'b1;
          cu.pc_cnt_en = 1'b1;
          ir_ld        = 1'b1;
        end
        T3: begin
          ir_oe = uses_operand(op);
          case (op)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: cu.mar_en = 1'b1;
            OP_LDI: cu.reg_A_wr = 1'b1;
            OP_OUT: begin
              cu.reg_A_rd = 1'b1;
              cu.seg7_en  = 1'b1;
            end
`ifdef CU_JMP_EN
            OP_JMP: cu.pc_ld = 1'b1;
`endif
            default: ;
          endcase
        end
        T4: begin
          case (op)
            OP_LDA: begin
              cu.ram_rd   = 1'b1;
              cu.reg_A_wr = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              cu.ram_rd   = 1'b1;
              cu.reg_B_wr = 1'b1;
            end
            OP_STA: begin
              cu.reg_A_rd = 1'b1;
              cu.ram_wr   = 1'b1;
            end
            default: ;
          endcase
        end
        T5: begin
          if (op == OP_ADD || op == OP_SUB) begin
            cu.alu_en   = 1'b1;
            cu.reg_A_wr = 1'b1;
            cu.alu_sel  = (op == OP_SUB) ? ALU_SUB : ALU_ADD;
          end
        end
        default: ;
      endcase
    end
  end

  assign cu.halt   = halt_q | halt_hit;
  assign cu.tstate = state_q;
  assign cu.opcode = op;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - scoreboard bench for control_unit with a tiny PC/MAR/RAM model on the shared bus
`timescale 1ns/1ps
module tb_control_unit;
  import cpu_pkg::*;

  localparam logic [12:0] C_PCO = 13'h1000;
  localparam logic [12:0] C_PCC = 13'h0800;
  localparam logic [12:0] C_MAR = 13'h0400;
  localparam logic [12:0] C_RRD = 13'h0200;
  localparam logic [12:0] C_RWR = 13'h0100;
  localparam logic [12:0] C_AWR = 13'h0080;
  localparam logic [12:0] C_ARD = 13'h0040;
  localparam logic [12:0] C_BWR = 13'h0020;
  localparam logic [12:0] C_ALU = 13'h0008;
  localparam logic [12:0] C_SUB = 13'h0002;
  localparam logic [12:0] C_SEG = 13'h0001;

  typedef struct packed {
    logic [2:0]  ts;
    logic [12:0] ctl;
    logic        hlt;
    logic [7:0]  bv;
    logic        pl;
    logic [3:0]  opc;
  } rec_t;

  logic clk;
  logic clr_n;
  wire  [7:0] bus;
  logic [7:0] mem [16];
  logic [3:0] pc;
  logic [3:0] mar;
  logic       tb_drv;
  logic [7:0] tb_val;
  logic [3:0] exp_pc;
  logic [7:0] exp_ir;
  rec_t       q[$];
  int         total;
  int         bad;

  control_unit_if cu ();

  control_unit dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus),
    .cu    (cu.master)
  );

  pullup (bus);
  assign tb_drv = cu.pc_out_en | cu.ram_rd;
  assign tb_val = cu.pc_out_en ? {4'h0, pc} : mem[mar];
  assign bus    = tb_drv ? tb_val : 8'hzz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pc  <= 4'h0;
      mar <= 4'h0;
    end else begin
      if (cu.mar_en) mar <= bus[3:0];
      if (cu.pc_cnt_en) pc <= pc + 4'h1;
`ifdef CU_JMP_EN
      if (cu.pc_ld) pc <= bus[3:0];
`endif
    end
  end

  task automatic check_eq(input string tag, input logic [29:0] got, input logic [29:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  function automatic logic [29:0] observe();
    rec_t o;
    o.ts  = cu.tstate;
    o.ctl = {cu.pc_out_en, cu.pc_cnt_en, cu.mar_en, cu.ram_rd, cu.ram_wr,
             cu.reg_A_wr, cu.reg_A_rd, cu.reg_B_wr, cu.reg_B_rd,
             cu.alu_en, cu.alu_sel, cu.seg7_en};
    o.hlt = cu.halt;
    o.bv  = bus;
`ifdef CU_JMP_EN
    o.pl  = cu.pc_ld;
`else
    o.pl  = 1'b0;
`endif
    o.opc = cu.opcode;
    return o;
  endfunction

  task automatic push(input logic [2:0] ts, input logic [12:0] ctl, input logic hlt,
                      input logic [7:0] bv, input logic pl);
    rec_t r;
    r.ts = ts; r.ctl = ctl; r.hlt = hlt; r.bv = bv; r.pl = pl; r.opc = exp_ir[7:4];
    q.push_back(r);
  endtask

  // Expected per-cycle view of one instruction, from the instruction's own semantics.
  task automatic push_instr(input logic [7:0] ins);
    logic [3:0] opd;
    opd = ins[3:0];
    push(3'd0, C_PCO | C_MAR, 1'b0, {4'h0, exp_pc}, 1'b0);
    push(3'd1, C_RRD | C_PCC, 1'b0, mem[exp_pc], 1'b0);
    exp_pc = exp_pc + 4'h1;
    exp_ir = ins;
    case (ins[7:4])
      4'h0: begin
        push(3'd2, C_MAR, 1'b0, {4'h0, opd}, 1'b0);
        push(3'd3, C_RRD | C_AWR, 1'b0, mem[opd], 1'b0);
      end
      4'h1, 4'h2: begin
        push(3'd2, C_MAR, 1'b0, {4'h0, opd}, 1'b0);
        push(3'd3, C_RRD | C_BWR, 1'b0, mem[opd], 1'b0);
        push(3'd4, C_ALU | C_AWR | ((ins[7:4] == 4'h2) ? C_SUB : 13'h0), 1'b0, 8'hFF, 1'b0);
      end
      4'h3: begin
        push(3'd2, C_MAR, 1'b0, {4'h0, opd}, 1'b0);
        push(3'd3, C_ARD | C_RWR, 1'b0, 8'hFF, 1'b0);
      end
      4'h4: push(3'd2, C_AWR, 1'b0, {4'h0, opd}, 1'b0);
      4'hE: push(3'd2, C_ARD | C_SEG, 1'b0, 8'hFF, 1'b0);
      4'hF: for (int i = 0; i < 22; i++) push(3'd2, 13'h0, 1'b1, 8'hFF, 1'b0);
`ifdef CU_JMP_EN
      4'h5: begin
        push(3'd2, 13'h0, 1'b0, {4'h0, opd}, 1'b1);
        exp_pc = opd;
      end
`endif
      default: push(3'd2, 13'h0, 1'b0, 8'hFF, 1'b0);
    endcase
  endtask

  task automatic drain_n(input string tag, input int n);
    rec_t r;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      #1;
      r = q.pop_front();
      check_eq(tag, observe(), r);
      @(negedge clk);
    end
  endtask

  task automatic drain(input string tag);
    drain_n(tag, q.size());
  endtask

  task automatic load_prog(input logic [7:0] b0, input logic [7:0] b1);
    for (int i = 0; i < 16; i++) mem[i] = 8'h30 + 8'(i);
    mem[0] = b0;
    mem[1] = b1;
  endtask

  task automatic do_reset();
    rec_t r;
    @(negedge clk);
    clr_n = 1'b0;
    cu.prog_en = 1'b0;
    #1;
    r = '0; r.bv = 8'hFF;
    check_eq("reset", observe(), r);
    @(negedge clk);
    clr_n  = 1'b1;
    exp_pc = 4'h0;
    exp_ir = 8'h00;
    q.delete();
  endtask

  initial begin
    rec_t r;
    total = 0;
    bad = 0;
    clr_n = 1'b0;
    cu.prog_en = 1'b0;
    exp_pc = 4'h0;
    exp_ir = 8'h00;
    load_prog(8'h00, 8'h00);

    // LDI 7 then HLT
    load_prog(8'h47, 8'hF0);
    do_reset();
    push_instr(8'h47); push_instr(8'hF0); drain("ldi");

    // ADD from RAM[14] then HLT
    load_prog(8'h1E, 8'hF0);
    mem[14] = 8'h5A;
    do_reset();
    push_instr(8'h1E); push_instr(8'hF0); drain("add");

    // SUB from RAM[9] then HLT
    load_prog(8'h29, 8'hF0);
    do_reset();
    push_instr(8'h29); push_instr(8'hF0); drain("sub");

    // STA then HLT held 20+ cycles
    load_prog(8'h3F, 8'hF0);
    do_reset();
    push_instr(8'h3F); push_instr(8'hF0); drain("sta_hlt");

    // LDA then OUT then HLT
    load_prog(8'h0C, 8'hE0);
    mem[2] = 8'hF0;
    do_reset();
    push_instr(8'h0C); push_instr(8'hE0); push_instr(8'hF0); drain("lda_out");

    // Undefined opcode 0x90, then opcode 5 (JMP or NOP), then HLT
    load_prog(8'h90, 8'h5A);
    mem[2]  = 8'hF0;
    mem[10] = 8'hF0;
    do_reset();
    push_instr(8'h90); push_instr(8'h5A); push_instr(8'hF0); drain("nop_jmp");

    // Reset pulse in the middle of ADD T4
    load_prog(8'h1E, 8'hF0);
    mem[14] = 8'h66;
    do_reset();
    push_instr(8'h1E);
    drain_n("abort_pre", 3);
    #1;
    r = q.pop_front();
    check_eq("abort_t4", observe(), r);
    clr_n = 1'b0;
    #1;
    r = '0; r.bv = 8'hFF;
    check_eq("abort_rst", observe(), r);
    q.delete();
    @(negedge clk);
    clr_n  = 1'b1;
    exp_pc = 4'h0;
    exp_ir = 8'h00;
    push_instr(8'h1E); push_instr(8'hF0); drain("abort_rerun");

    // prog_en raised during LDA T3, then released
    load_prog(8'h0E, 8'hF0);
    do_reset();
    push_instr(8'h0E);
    drain_n("prog_pre", 2);
    cu.prog_en = 1'b1;
    #1;
    r = '0; r.ts = 3'd2; r.bv = 8'hFF; r.opc = 4'h0;
    check_eq("prog_t3", observe(), r);
    q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      r = '0; r.bv = 8'hFF; r.opc = 4'h0;
      check_eq("prog_hold", observe(), r);
    end
    @(negedge clk);
    cu.prog_en = 1'b0;
    push_instr(8'hF0); drain("prog_resume");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
Instruction register plus T-state sequencer for the 8-bit bus CPU. Fetches from RAM over the shared bus, latches the opcode and operand, and drives every control enable consumed by PC, MAR, RAM, Reg A/B, ALU and 7-seg output. Sits upstream of all datapath blocks and fills the missing control path in CPU_top.

Parameters:
DATA_W, 8, bus/IR width
OP_W, 4, opcode width (IR[7:4]); operand = IR[3:0]

Ports:
clk  input  1  system clock (gated clock from Clock_Ctrl)
clr_n  input  1  reset, asynchronous, active-low
prog_en  input  1  programming mode (ram_tog); freezes sequencer
bus  inout  8  shared bus; driven only while the operand is placed on the bus, else Z
pc_out_en  output  1  PC drives bus
pc_cnt_en  output  1  PC increment
mar_en  output  1  MAR loads from bus
ram_rd  output  1  RAM drives bus
ram_wr  output  1  RAM writes bus value
reg_A_wr  output  1  Reg A loads bus
reg_A_rd  output  1  Reg A drives bus
reg_B_wr  output  1  Reg B loads bus
reg_B_rd  output  1  Reg B drives bus (never asserted in base ISA; tied 0)
alu_en  output  1  ALU drives result on bus
alu_sel  output  2  00 add, 01 sub
seg7_en  output  1  output display latches bus
halt  output  1  sticky halt to Clock_Ctrl
tstate  output  3  current T-state, 0..4 = T1..T5 (debug)
opcode  output  4  IR[7:4] (debug)

Behaviour:
- Reset (clr_n=0, async): IR=0x00, tstate=T1, halt=0. All enables deassert combinationally, alu_sel=00, bus=Z.
- Control outputs are combinational decodes of (tstate, IR). Datapath blocks sample on the next rising clk. The sequencer advances once per clk.
- Fetch (all opcodes): T1 pc_out_en+mar_en. T2 ram_rd+pc_cnt_en, IR<=bus at the T2 edge.
- Execute (opcodes: 0 LDA, 1 ADD, 2 SUB, 3 STA, 4 LDI, E OUT, F HLT):
  LDA: T3 operand->bus, mar_en. T4 ram_rd, reg_A_wr. Then T1. 4 cycles total.
  ADD: T3 as LDA. T4 ram_rd, reg_B_wr. T5 alu_en, alu_sel=00, reg_A_wr. Then T1. 5 cycles.
  SUB: same as ADD with alu_sel=01 at T5.
  STA: T3 operand->bus, mar_en. T4 reg_A_rd, ram_wr. Then T1. 4 cycles.
  LDI: T3 operand->bus as {4'h0,IR[3:0]}, reg_A_wr. Then T1. 3 cycles.
  OUT: T3 reg_A_rd, seg7_en. Then T1. 3 cycles.
  HLT: at T3 set halt=1, hold tstate=T3, no enables. Only clr_n clears it.
  Undefined opcodes: NOP; T3 with no enables, then T1.
- The IR drives the bus only when the operand phase is active. The lower nibble is zero-extended. At most one bus driver is active per state (by construction).
- prog_en=1: tstate forced to T1 on the next edge, IR holds, all enables 0, bus=Z. Sequencer resumes at T1 when prog_en falls.
- clr_n mid-instruction: aborts immediately. The next fetch starts at T1 after release.
- halt is independent of prog_en. A halted CPU stays halted until reset.

Optional Feature:
CU_JMP_EN: adds output pc_ld (1 bit) and opcode 5 JMP. T3 drives the operand onto the bus and asserts pc_ld, then returns to T1 (3 cycles). Without the macro, pc_ld is absent and opcode 5 is a NOP.

Decomposition:
- Package cpu_pkg: opcode constants (OP_LDA..OP_HLT, OP_JMP), T-state encodings T1..T5, ALU_ADD/ALU_SUB select codes, DATA_W.
- One sub-module: instr_reg_8bit. It holds the IR register, has a load enable, and provides the tri-state operand driver. The control_unit keeps the sequencer and decode.

Test Plan:
- Reset: pulse clr_n low mid-T4 of ADD -> all enables 0 and tstate=0 within the same cycle; bus=Z; halt=0.
- LDI: RAM[0]=0x47 -> T2 loads IR=0x47; T3 bus=0x07 with reg_A_wr=1; tstate returns to 0 on the next edge.
- ADD: RAM[0]=0x1E -> T3 bus=0x0E with mar_en; T4 ram_rd+reg_B_wr; T5 alu_en, alu_sel=00, reg_A_wr; 5 cycles total.
- STA then HLT: program 0x3F, 0xF0 -> STA T4 reg_A_rd+ram_wr; HLT T3 halt=1 and stays 1 for 20+ cycles with no enables.
- prog_en asserted during T3 of LDA -> next edge tstate=0, enables 0; deassert -> fetch resumes from T1 with IR unchanged.
- Undefined opcode 0x90 -> no enables in T3, back to T1. With CU_JMP_EN, 0x5A -> T3 pc_ld=1, bus=0x0A.
